serial_frame_rx: RTL and testbench

Serial frame receiver that sits directly downstream of the synchronous-reset D flip-flop stage and consumes its registered serial bit stream. It hunts for a fixed sync pattern, deserialises the following data word MSB-first, presents it on a parallel bus with a one-cycle valid strobe, and counts received frames. It is a small FSMD: a control FSM with bit counters and shift registers.

---
 rtl/serial_frame_rx.sv | 185 ++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Serial frame receiver. Hunts for a fixed sync word in a registered
//   serial bit stream, deserialises the following DATA_W-bit word MSB-first,
//   presents it on data_out with a one-cycle data_valid strobe and counts
//   completed frames.
//
//   Optional feature macro: SERIAL_FRAME_PARITY_EN
//     defined   : one even-parity bit follows the data word; parity_err port
//     undefined : frame is sync + data only; no parity_err port
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   d_in       in   serial bit
//   d_valid    in   d_in is sampled only on edges where this is 1
//   data_out   out  [DATA_W] last complete data word, held until next frame
//   data_valid out  one-cycle pulse when data_out updates
//   sync_found out  one-cycle pulse when the sync word is matched
//   busy       out  high whenever the receiver is not hunting
//   frame_cnt  out  [8] completed frame count, wraps 255 -> 0
//   parity_err out  even-parity error of last frame (macro only)
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | shifting bits into the hunt register looking for the sync word
// COLLECT | shifting DATA_W data bits into the data register
// PARITY  | waiting for the parity bit (macro only)

module serial_frame_rx #(
   parameter int                DATA_W       = 8,
   parameter int                SYNC_W       = 4,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_in,
   input  logic              d_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              sync_found,
   output logic              busy,
   output logic [7:0]        frame_cnt
`ifdef SERIAL_FRAME_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int CNT_W  = $clog2(DATA_W);
   localparam int FILL_W = $clog2(SYNC_W + 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1
`ifdef SERIAL_FRAME_PARITY_EN
      ,
      PARITY  = 2'd2
`endif
   } state_t;

   state_t             state_q,      state_d;
   logic [SYNC_W-1:0]  hunt_sr_q,    hunt_sr_d;
   logic [FILL_W-1:0]  fill_q,       fill_d;
   logic [DATA_W-1:0]  data_sr_q,    data_sr_d;
   logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
   logic [DATA_W-1:0]  data_out_q,   data_out_d;
   logic               data_valid_q, data_valid_d;
   logic               sync_found_q, sync_found_d;
   logic [7:0]         frame_cnt_q,  frame_cnt_d;
`ifdef SERIAL_FRAME_PARITY_EN
   logic               parity_err_q, parity_err_d;
`endif

   logic [SYNC_W-1:0]  hunt_next;
   logic [DATA_W-1:0]  data_next;
   logic               unused_msbs;

   // The oldest bit of each shift register falls off the end on the next
   // shift and is only ever observed through the shifted value.
   assign hunt_next   = {hunt_sr_q[SYNC_W-2:0], d_in};
   assign data_next   = {data_sr_q[DATA_W-2:0], d_in};
   assign unused_msbs = hunt_sr_q[SYNC_W-1] ^ data_sr_q[DATA_W-1];

   always_comb begin
      state_d      = state_q;
      hunt_sr_d    = hunt_sr_q;
      fill_d       = fill_q;
      data_sr_d    = data_sr_q;
      bit_cnt_d    = bit_cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      sync_found_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
`ifdef SERIAL_FRAME_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (d_valid) begin
         case (state_q)
            HUNT: begin
               if ((fill_q >= FILL_W'(SYNC_W - 1)) && (hunt_next == SYNC_PATTERN)) begin
                  // Clear the hunt history on the way out so the next hunt
                  // starts empty and data bits never feed a match.
                  state_d      = COLLECT;
                  hunt_sr_d    = '0;
                  fill_d       = '0;
                  bit_cnt_d    = '0;
                  sync_found_d = 1'b1;
               end else begin
                  hunt_sr_d = hunt_next;
                  if (fill_q != FILL_W'(SYNC_W)) begin
                     fill_d = fill_q + 1'b1;
                  end
               end
            end
            COLLECT: begin
               data_sr_d = data_next;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_d = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d      = HUNT;
                  data_out_d   = data_next;
                  data_valid_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 8'd1;
`endif
               end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PARITY: begin
               state_d      = HUNT;
               data_out_d   = data_sr_q;
               data_valid_d = 1'b1;
               parity_err_d = ^{data_sr_q, d_in};
               frame_cnt_d  = frame_cnt_q + 8'd1;
            end
`endif
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HUNT;
         hunt_sr_q    <= '0;
         fill_q       <= '0;
         data_sr_q    <= '0;
         bit_cnt_q    <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         sync_found_q <= 1'b0;
         frame_cnt_q  <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         hunt_sr_q    <= hunt_sr_d;
         fill_q       <= fill_d;
         data_sr_q    <= data_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         sync_found_q <= sync_found_d;
         frame_cnt_q  <= frame_cnt_d;
`ifdef SERIAL_FRAME_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign sync_found = sync_found_q;
   assign busy       = (state_q != HUNT);
   assign frame_cnt  = frame_cnt_q;
`ifdef SERIAL_FRAME_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx. The reference model scans the whole bit
// stream with a sliding window to locate sync words and frame boundaries,
// then every clock is compared against the expectations it produced.
module tb_serial_frame_rx;

   localparam int                DATA_W       = 8;
   localparam int                SYNC_W       = 4;
   localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;
`ifdef SERIAL_FRAME_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_LEN = SYNC_W + DATA_W + PAR_BITS;

   logic              clk     = 1'b0;
   logic              reset   = 1'b1;
   logic              d_in    = 1'b0;
   logic              d_valid = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              sync_found;
   logic              busy;
   logic [7:0]        frame_cnt;
`ifdef SERIAL_FRAME_PARITY_EN
   logic              parity_err;
`endif

   int total = 0;
   int bad   = 0;

   bit                stream[$];
   bit                m_sync[$];
   bit                m_end[$];
   bit                m_busy[$];
   bit                m_perr[$];
   logic [DATA_W-1:0] m_word[$];

   logic [DATA_W-1:0] cur_do;
   logic [7:0]        cur_fc;
   bit                cur_busy;
   bit                cur_perr;
   int                dv_seen;
   int                first_dv_edge;

   serial_frame_rx #(
      .DATA_W       (DATA_W),
      .SYNC_W       (SYNC_W),
      .SYNC_PATTERN (SYNC_PATTERN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .d_in       (d_in),
      .d_valid    (d_valid),
      .data_out   (data_out),
      .data_valid (data_valid),
      .sync_found (sync_found),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
`ifdef SERIAL_FRAME_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic void push_bits(input logic [31:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) stream.push_back(v[i]);
   endfunction

   function automatic void push_frame(input logic [DATA_W-1:0] w, input bit par);
      push_bits(32'(SYNC_PATTERN), SYNC_W);
      push_bits(32'(w), DATA_W);
      if (PAR_BITS == 1) stream.push_back(par);
   endfunction

   function automatic void build_model();
      int n = stream.size();
      int hs = 0;
      int i = 0;
      int e;
      bit hit;
      logic [SYNC_W-1:0] pat = SYNC_PATTERN;
      logic [DATA_W-1:0] w;
      m_sync.delete(); m_end.delete(); m_busy.delete(); m_perr.delete(); m_word.delete();
      for (int k = 0; k < n; k++) begin
         m_sync.push_back(1'b0); m_end.push_back(1'b0); m_busy.push_back(1'b0);
         m_perr.push_back(1'b0); m_word.push_back('0);
      end
      while (i < n) begin
         hit = 1'b0;
         if (i - hs + 1 >= SYNC_W) begin
            hit = 1'b1;
            for (int j = 0; j < SYNC_W; j++)
               if (stream[i - SYNC_W + 1 + j] != pat[SYNC_W - 1 - j]) hit = 1'b0;
         end
         if (!hit) begin
            i++;
            continue;
         end
         m_sync[i] = 1'b1;
         e = i + DATA_W + PAR_BITS;
         for (int k = i; k < e && k < n; k++) m_busy[k] = 1'b1;
         if (e < n) begin
            w = '0;
            for (int j = 1; j <= DATA_W; j++) w = (w << 1) | DATA_W'(stream[i + j]);
            m_end[e]  = 1'b1;
            m_word[e] = w;
            if (PAR_BITS == 1) m_perr[e] = (^w) ^ stream[e];
         end
         hs = e + 1;
         i  = e + 1;
      end
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      d_valid = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      cur_do   = '0;
      cur_fc   = '0;
      cur_busy = 1'b0;
      cur_perr = 1'b0;
   endtask

   // mode 0: d_valid every cycle, 1: one idle cycle after every bit, 2: random gaps
   task automatic run_stream(input int mode);
      int n_idle;
      int edge_no = 0;
      build_model();
      dv_seen       = 0;
      first_dv_edge = -1;
      for (int k = 0; k < stream.size(); k++) begin
         d_in    = stream[k];
         d_valid = 1'b1;
         @(posedge clk);
         edge_no++;
         @(negedge clk);
         if (m_end[k]) begin
            cur_do   = m_word[k];
            cur_fc   = cur_fc + 8'd1;
            cur_perr = m_perr[k];
         end
         cur_busy = m_busy[k];
         if (data_valid === 1'b1) begin
            dv_seen++;
            if (first_dv_edge < 0) first_dv_edge = edge_no;
         end
         total++;
         if (data_valid !== m_end[k]) begin
            bad++; $display("FAIL data_valid bit=%0d got=%b exp=%b", k, data_valid, m_end[k]);
         end
         total++;
         if (sync_found !== m_sync[k]) begin
            bad++; $display("FAIL sync_found bit=%0d got=%b exp=%b", k, sync_found, m_sync[k]);
         end
         total++;
         if (busy !== cur_busy) begin
            bad++; $display("FAIL busy bit=%0d got=%b exp=%b", k, busy, cur_busy);
         end
         total++;
         if (data_out !== cur_do) begin
            bad++; $display("FAIL data_out bit=%0d got=%h exp=%h", k, data_out, cur_do);
         end
         total++;
         if (frame_cnt !== cur_fc) begin
            bad++; $display("FAIL frame_cnt bit=%0d got=%0d exp=%0d", k, frame_cnt, cur_fc);
         end
`ifdef SERIAL_FRAME_PARITY_EN
         total++;
         if (parity_err !== cur_perr) begin
            bad++; $display("FAIL parity_err bit=%0d got=%b exp=%b", k, parity_err, cur_perr);
         end
`endif
         n_idle = (mode == 1) ? 1 :
                  (mode == 2) ? (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0) : 0;
         for (int g = 0; g < n_idle; g++) begin
            d_valid = 1'b0;
            d_in    = 1'($urandom_range(0, 1));
            @(posedge clk);
            edge_no++;
            @(negedge clk);
            total++;
            if (data_valid !== 1'b0 || sync_found !== 1'b0) begin
               bad++; $display("FAIL idle_pulse bit=%0d got dv=%b sf=%b exp 0", k, data_valid, sync_found);
            end
            total++;
            if (busy !== cur_busy || data_out !== cur_do || frame_cnt !== cur_fc) begin
               bad++; $display("FAIL idle_hold bit=%0d got busy=%b do=%h fc=%0d exp busy=%b do=%h fc=%0d",
                               k, busy, data_out, frame_cnt, cur_busy, cur_do, cur_fc);
            end
         end
      end
      d_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (data_out !== '0 || frame_cnt !== 8'd0) begin
         bad++; $display("FAIL reset_regs got do=%h fc=%0d exp 0", data_out, frame_cnt);
      end
      total++;
      if (data_valid !== 1'b0 || sync_found !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_flags got dv=%b sf=%b busy=%b exp 0", data_valid, sync_found, busy);
      end
`ifdef SERIAL_FRAME_PARITY_EN
      total++;
      if (parity_err !== 1'b0) begin
         bad++; $display("FAIL reset_perr got=%b exp=0", parity_err);
      end
`endif
      apply_reset();
   endtask

   task automatic test_basic();
      apply_reset();
      stream.delete();
      push_frame(8'h3C, 1'b0);
      run_stream(0);
      total++;
      if (data_out !== 8'h3C || frame_cnt !== 8'd1) begin
         bad++; $display("FAIL basic_result got do=%h fc=%0d exp 3c/1", data_out, frame_cnt);
      end
      total++;
      if (first_dv_edge != FRAME_LEN || dv_seen != 1) begin
         bad++; $display("FAIL basic_timing got edge=%0d pulses=%0d exp %0d/1", first_dv_edge, dv_seen, FRAME_LEN);
      end
   endtask

   task automatic test_gapped();
      apply_reset();
      stream.delete();
      push_frame(8'h3C, 1'b0);
      run_stream(1);
      total++;
      if (data_out !== 8'h3C || frame_cnt !== 8'd1) begin
         bad++; $display("FAIL gapped_result got do=%h fc=%0d exp 3c/1", data_out, frame_cnt);
      end
      total++;
      if (first_dv_edge != 2 * FRAME_LEN - 1) begin
         bad++; $display("FAIL gapped_timing got edge=%0d exp=%0d", first_dv_edge, 2 * FRAME_LEN - 1);
      end
   endtask

   task automatic test_false_sync();
      apply_reset();
      stream.delete();
      push_bits(32'b10, 2);
      push_frame(8'hA5, 1'b0);
      push_frame(8'hFF, 1'b0);
      run_stream(0);
      total++;
      if (data_out !== 8'hFF || frame_cnt !== 8'd2 || dv_seen != 2) begin
         bad++; $display("FAIL false_sync got do=%h fc=%0d pulses=%0d exp ff/2/2", data_out, frame_cnt, dv_seen);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      stream.delete();
      push_bits(32'(SYNC_PATTERN), SYNC_W);
      push_bits(32'b1000, 4);
      run_stream(0);
      #1 reset = 1'b1;
      #1;
      total++;
      if (data_out !== '0 || frame_cnt !== 8'd0 || data_valid !== 1'b0 ||
          sync_found !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset got do=%h fc=%0d dv=%b sf=%b busy=%b exp 0",
                         data_out, frame_cnt, data_valid, sync_found, busy);
      end
      #2 reset = 1'b0;
      cur_do = '0; cur_fc = '0; cur_busy = 1'b0; cur_perr = 1'b0;
      @(negedge clk);
      stream.delete();
      push_frame(8'h81, 1'b0);
      run_stream(0);
      total++;
      if (data_out !== 8'h81 || frame_cnt !== 8'd1) begin
         bad++; $display("FAIL after_reset got do=%h fc=%0d exp 81/1", data_out, frame_cnt);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      stream.delete();
      for (int f = 0; f < 256; f++) push_frame(8'h00, 1'b0);
      run_stream(0);
      total++;
      if (frame_cnt !== 8'd0 || dv_seen != 256) begin
         bad++; $display("FAIL wrap got fc=%0d pulses=%0d exp 0/256", frame_cnt, dv_seen);
      end
   endtask

`ifdef SERIAL_FRAME_PARITY_EN
   task automatic test_parity();
      apply_reset();
      stream.delete();
      push_frame(8'h3C, 1'b0);
      run_stream(0);
      total++;
      if (parity_err !== 1'b0 || data_out !== 8'h3C) begin
         bad++; $display("FAIL parity_ok got perr=%b do=%h exp 0/3c", parity_err, data_out);
      end
      stream.delete();
      push_frame(8'h3C, 1'b1);
      run_stream(0);
      total++;
      if (parity_err !== 1'b1 || data_out !== 8'h3C || frame_cnt !== 8'd2) begin
         bad++; $display("FAIL parity_bad got perr=%b do=%h fc=%0d exp 1/3c/2", parity_err, data_out, frame_cnt);
      end
   endtask
`endif

   task automatic test_random(input int mode);
      int noise;
      apply_reset();
      stream.delete();
      for (int f = 0; f < 30; f++) begin
         noise = $urandom_range(0, 5);
         for (int b = 0; b < noise; b++) stream.push_back(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) != 0) push_frame(DATA_W'($urandom), 1'($urandom_range(0, 1)));
      end
      run_stream(mode);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_false_sync();
      test_reset_mid();
      test_wrap();
`ifdef SERIAL_FRAME_PARITY_EN
      test_parity();
`endif
      test_random(0);
      test_random(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
